// File: rtl/fft_pkg.sv
// Shared constants, types and index helpers for the 64-point FFT datapath.
// The input writer and the output reader both use bitrev6/parity6, so the
// two ends agree on where every sample lives.
package fft_pkg;

  localparam int FFT_LOG2N  = 6;
  localparam int FFT_N      = 64;
  localparam int BANK_DEPTH = 32;
  localparam int FFT_DW     = 16;

  // One bank word: real part in the upper half, imaginary part in the lower half
  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  // Output reader sequencing states
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

  // Mirror a 6-bit index (bit 0 <-> bit 5, ...)
  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 0; i < 6; i++) begin
      r[i] = v[5-i];
    end
    return r;
  endfunction

  // Bank select: even-parity positions live in bank0, odd in bank1
  function automatic logic parity6(input logic [5:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/fft_skid_fifo2.sv
// Two-entry valid/ready FIFO. The head word comes straight from a storage
// register, so the output is stable for as long as it is not accepted.
module fft_skid_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem0;
  logic [W-1:0] r_mem1;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  // Handshake qualification; a push into a full FIFO is only legal alongside a pop
  always_comb begin
    w_pop = (r_count != 2'd0) & i_ready;
    if ((r_count != 2'd2) || w_pop) begin
      w_push = i_push;
    end else begin
      w_push = 1'b0;
    end
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0   <= {W{1'b0}};
      r_mem1   <= {W{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr_ptr) begin
          r_mem1 <= i_data;
        end else begin
          r_mem0 <= i_data;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head of queue
  always_comb begin
    o_valid = (r_count != 2'd0);
    o_count = r_count;
    if (r_rd_ptr) begin
      o_data = r_mem1;
    end else begin
      o_data = r_mem0;
    end
  end

endmodule

// File: rtl/fft_output_reader.sv
// Drains a finished 64-point FFT frame from the two parity-interleaved banks
// and streams it in natural frequency order on a valid/ready interface.
// Reads are issued only when the 2-entry buffer is guaranteed to have room,
// so any out_ready pattern is tolerated without loss.
module fft_output_reader
  import fft_pkg::*;
#(
  parameter int DW     = 16,
  parameter int LOG2N  = 6,
  parameter bit BITREV = 1'b1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  output logic                   re_b0,
  output logic [LOG2N-2:0]       raddr_b0,
  input  logic [2*DW-1:0]        rdata_b0,
  output logic                   re_b1,
  output logic [LOG2N-2:0]       raddr_b1,
  input  logic [2*DW-1:0]        rdata_b1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DW-1:0]   out_re,
  output logic signed [DW-1:0]   out_im,
  output logic [LOG2N-1:0]       out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = LOG2N - 1;
  localparam int WW = 2 * DW;
  localparam logic [LOG2N-1:0] K_LAST = {LOG2N{1'b1}};

  rd_state_e         r_state;
  logic [LOG2N-1:0]  r_k;
  logic [LOG2N-1:0]  r_oidx;
  logic              r_tag_v;
  logic              r_tag_bank;
  logic              r_busy;
  logic              r_done;

  logic [LOG2N-1:0]  w_p;
  logic              w_bank;
  logic [AW-1:0]     w_addr;
  logic              w_issue;
  logic [2:0]        w_used;
  logic              w_clr;
  logic              w_push;
  logic [WW-1:0]     w_push_data;
  logic              w_pop;
  logic              w_valid;
  logic [WW-1:0]     w_head;
  logic [1:0]        w_count;
  logic              w_last;

  // Stored position, bank and word address of the next sample to fetch
  always_comb begin
    if (BITREV) begin
      w_p = bitrev6(r_k);
    end else begin
      w_p = r_k;
    end
    w_bank = parity6(w_p);
    w_addr = w_p[LOG2N-1:1];
  end

  // Credit: buffered + returning + new read must fit in two entries; a word
  // leaving the buffer this cycle frees its slot for the new read
  always_comb begin
    w_pop  = w_valid & out_ready;
    w_used = {1'b0, w_count} + {2'b00, r_tag_v} - {2'b00, w_pop};
    if ((r_state == RD_READ) && (w_used < 3'd2)) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
  end

  // Bank read ports: only the selected bank is enabled, the other address idles at 0
  always_comb begin
    re_b0    = 1'b0;
    re_b1    = 1'b0;
    raddr_b0 = {AW{1'b0}};
    raddr_b1 = {AW{1'b0}};
    if (w_issue) begin
      if (w_bank) begin
        re_b1    = 1'b1;
        raddr_b1 = w_addr;
      end else begin
        re_b0    = 1'b1;
        raddr_b0 = w_addr;
      end
    end else begin
      re_b0    = 1'b0;
      re_b1    = 1'b0;
    end
  end

  // Returning data is steered by the bank tag captured when the read was issued
  always_comb begin
    w_push = r_tag_v;
    w_clr  = (r_state == RD_IDLE) & start;
    w_last = w_valid & (r_oidx == K_LAST);
    if (r_tag_bank) begin
      w_push_data = rdata_b1;
    end else begin
      w_push_data = rdata_b0;
    end
  end

  fft_skid_fifo2 #(
    .W (WW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (nrst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_ready (out_ready),
    .o_valid (w_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // Frame sequencing, issue/output counters, read tag and status flags
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= RD_IDLE;
      r_k        <= {LOG2N{1'b0}};
      r_oidx     <= {LOG2N{1'b0}};
      r_tag_v    <= 1'b0;
      r_tag_bank <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_tag_v    <= w_issue;
      r_tag_bank <= w_bank;
      if (w_pop) begin
        r_oidx <= r_oidx + {{(LOG2N-1){1'b0}}, 1'b1};
      end
      case (r_state)
        RD_IDLE: begin
          if (start) begin
            r_state <= RD_READ;
            r_k     <= {LOG2N{1'b0}};
            r_oidx  <= {LOG2N{1'b0}};
            r_busy  <= 1'b1;
          end
        end
        RD_READ: begin
          if (w_issue) begin
            r_k <= r_k + {{(LOG2N-1){1'b0}}, 1'b1};
            if (r_k == K_LAST) begin
              r_state <= RD_DRAIN;
            end
          end
        end
        RD_DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= RD_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= RD_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stream is the buffer head; index and last flag follow the output counter
  always_comb begin
    out_valid = w_valid;
    out_re    = w_head[WW-1:DW];
    out_im    = w_head[DW-1:0];
    out_idx   = r_oidx;
    out_last  = w_last;
    busy      = r_busy;
    done      = r_done;
  end

endmodule
